// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common-data-bus arbiter:
//   - source encodings (ALU / LSQ / BRA) and the number of sources
//   - the result-entry record carried through each holding FIFO
//   - a helper returning the next source in round-robin order
// The entry's dest field is sized for the widest ROB index supported
// (DEST_MAX_W); narrower ROB indices are zero-extended on the way in and
// truncated on the way out.
// -----------------------------------------------------------------------------
package cdb_pkg;

  localparam int NUM_SRC    = 3;
  localparam int DEST_MAX_W = 16;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSQ = 2'd1,
    SRC_BRA = 2'd2
  } src_e;

  typedef struct packed {
    logic [31:0]           data;
    logic [DEST_MAX_W-1:0] dest;
    logic                  jump_en;
    logic [31:0]           jump_addr;
  } cdb_entry_t;

  // Successor of a source in the rotation ALU -> LSQ -> BRA -> ALU.
  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_ALU: next_src = SRC_LSQ;
      SRC_LSQ: next_src = SRC_BRA;
      default: next_src = SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
// DEPTH-entry in-order holding FIFO for one result source.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop all entries; a push in the same cycle is discarded
//   push_valid      producer offers push_entry
//   push_ready      occupancy below DEPTH (registered count, no pop bypass);
//                   forced low while rst is high
//   push_entry      result record to store
//   pop             consumer removes the head entry this cycle
//   empty           no entries held
//   head            oldest entry (meaningful only when !empty)
// -----------------------------------------------------------------------------
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push_valid,
  output logic       push_ready,
  input  cdb_entry_t push_entry,
  input  logic       pop,
  output logic       empty,
  output cdb_entry_t head
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_next = '0;
    end else begin
      ptr_next = p + PTR_W'(1);
    end
  endfunction

  // Ready looks only at the registered count, so a same-cycle pop never
  // makes room for a same-cycle push.
  assign push_ready = !rst && (count < CNT_MAX);
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign do_push    = push_valid && push_ready && !flush;
  assign do_pop     = pop && !empty && !flush;

  // Pointer and occupancy bookkeeping; reset and flush both drop every entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Collects results from the ALU, LSQ and branch unit into per-source holding
// FIFOs and broadcasts at most one per cycle on the common data bus.
//
// Build option:
//   CDB_RR_EN  defined   -> round-robin arbitration; after a grant to source s
//                           the search starts at (s+1) mod 3; pointer resets
//                           to ALU on rst or flush
//              undefined -> fixed priority BRA > LSQ > ALU
//
// Parameters: ROB_W (ROB index width, <= DEST_MAX_W), DEPTH (FIFO depth, >=1)
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush                        misprediction rollback, empties all FIFOs
//   alu_valid/ready/data/dest    ALU result handshake
//   lsq_valid/ready/data/dest    LSQ result handshake
//   bra_valid/ready/data/dest    branch result handshake
//   bra_jump_en, bra_jump_addr   branch redirect info
//   cdb_valid, cdb_src           registered broadcast strobe and source
//   cdb_data, cdb_dest           registered broadcast payload
//   cdb_jump_en, cdb_jump_addr   registered redirect (nonzero only for BRA)
// All cdb_* outputs are zero in any cycle without a broadcast.
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int ROB_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [31:0]      alu_data,
  input  logic [ROB_W-1:0] alu_dest,
  input  logic             lsq_valid,
  output logic             lsq_ready,
  input  logic [31:0]      lsq_data,
  input  logic [ROB_W-1:0] lsq_dest,
  input  logic             bra_valid,
  output logic             bra_ready,
  input  logic [31:0]      bra_data,
  input  logic [ROB_W-1:0] bra_dest,
  input  logic             bra_jump_en,
  input  logic [31:0]      bra_jump_addr,
  output logic             cdb_valid,
  output logic [1:0]       cdb_src,
  output logic [31:0]      cdb_data,
  output logic [ROB_W-1:0] cdb_dest,
  output logic             cdb_jump_en,
  output logic [31:0]      cdb_jump_addr
);

  cdb_entry_t alu_entry;
  cdb_entry_t lsq_entry;
  cdb_entry_t bra_entry;
  cdb_entry_t alu_head;
  cdb_entry_t lsq_head;
  cdb_entry_t bra_head;
  cdb_entry_t sel_entry;
  logic       alu_empty;
  logic       lsq_empty;
  logic       bra_empty;
  logic       alu_pop;
  logic       lsq_pop;
  logic       bra_pop;
  logic       grant_any;
  src_e       grant_src;

`ifdef CDB_RR_EN
  src_e rr_ptr;
  src_e cand;
  logic cand_req;
`endif

  // Pack incoming results; ALU and LSQ never carry a redirect.
  always_comb begin
    alu_entry           = '0;
    alu_entry.data      = alu_data;
    alu_entry.dest      = DEST_MAX_W'(alu_dest);
    alu_entry.jump_en   = 1'b0;
    alu_entry.jump_addr = 32'h0;

    lsq_entry           = '0;
    lsq_entry.data      = lsq_data;
    lsq_entry.dest      = DEST_MAX_W'(lsq_dest);
    lsq_entry.jump_en   = 1'b0;
    lsq_entry.jump_addr = 32'h0;

    bra_entry           = '0;
    bra_entry.data      = bra_data;
    bra_entry.dest      = DEST_MAX_W'(bra_dest);
    bra_entry.jump_en   = bra_jump_en;
    bra_entry.jump_addr = bra_jump_addr;
  end

  cdb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (alu_valid),
    .push_ready (alu_ready),
    .push_entry (alu_entry),
    .pop        (alu_pop),
    .empty      (alu_empty),
    .head       (alu_head)
  );

  cdb_fifo #(.DEPTH(DEPTH)) u_lsq_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (lsq_valid),
    .push_ready (lsq_ready),
    .push_entry (lsq_entry),
    .pop        (lsq_pop),
    .empty      (lsq_empty),
    .head       (lsq_head)
  );

  cdb_fifo #(.DEPTH(DEPTH)) u_bra_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (bra_valid),
    .push_ready (bra_ready),
    .push_entry (bra_entry),
    .pop        (bra_pop),
    .empty      (bra_empty),
    .head       (bra_head)
  );

`ifdef CDB_RR_EN
  // Round-robin grant: scan the three sources starting at rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_src = SRC_ALU;
    cand      = rr_ptr;
    cand_req  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      case (cand)
        SRC_ALU: cand_req = !alu_empty;
        SRC_LSQ: cand_req = !lsq_empty;
        SRC_BRA: cand_req = !bra_empty;
        default: cand_req = 1'b0;
      endcase
      if (!grant_any && cand_req) begin
        grant_any = 1'b1;
        grant_src = cand;
      end else begin
        grant_any = grant_any;
      end
      cand = next_src(cand);
    end
  end

  // Rotation pointer moves past the winner only when a grant happens.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr <= SRC_ALU;
    end else if (grant_any) begin
      rr_ptr <= next_src(grant_src);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end
`else
  // Fixed-priority grant: branch results first so redirects resolve early.
  always_comb begin
    grant_any = 1'b0;
    grant_src = SRC_ALU;
    if (!bra_empty) begin
      grant_any = 1'b1;
      grant_src = SRC_BRA;
    end else if (!lsq_empty) begin
      grant_any = 1'b1;
      grant_src = SRC_LSQ;
    end else if (!alu_empty) begin
      grant_any = 1'b1;
      grant_src = SRC_ALU;
    end else begin
      grant_any = 1'b0;
      grant_src = SRC_ALU;
    end
  end
`endif

  // Pops are suppressed under rst/flush; the FIFOs are being cleared anyway.
  assign alu_pop = grant_any && (grant_src == SRC_ALU) && !flush && !rst;
  assign lsq_pop = grant_any && (grant_src == SRC_LSQ) && !flush && !rst;
  assign bra_pop = grant_any && (grant_src == SRC_BRA) && !flush && !rst;

  // Head of the granted FIFO.
  always_comb begin
    sel_entry = '0;
    case (grant_src)
      SRC_ALU: sel_entry = alu_head;
      SRC_LSQ: sel_entry = lsq_head;
      SRC_BRA: sel_entry = bra_head;
      default: sel_entry = '0;
    endcase
  end

  // Broadcast register; zero payload in any cycle without a grant.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cdb_valid     <= 1'b0;
      cdb_src       <= 2'd0;
      cdb_data      <= 32'h0;
      cdb_dest      <= '0;
      cdb_jump_en   <= 1'b0;
      cdb_jump_addr <= 32'h0;
    end else if (grant_any) begin
      cdb_valid     <= 1'b1;
      cdb_src       <= grant_src;
      cdb_data      <= sel_entry.data;
      cdb_dest      <= ROB_W'(sel_entry.dest);
      cdb_jump_en   <= sel_entry.jump_en;
      cdb_jump_addr <= sel_entry.jump_addr;
    end else begin
      cdb_valid     <= 1'b0;
      cdb_src       <= 2'd0;
      cdb_data      <= 32'h0;
      cdb_dest      <= '0;
      cdb_jump_en   <= 1'b0;
      cdb_jump_addr <= 32'h0;
    end
  end

endmodule
